// File: rtl/fifo_stream_reader_pkg.sv
// Shared FIFO constants and helpers for the stream reader and its skid queue.
// The skid queue is a 3-entry circular buffer, so its pointers wrap 2 -> 0.
package fifo_stream_reader_pkg;

   localparam int FIFO_DEPTH   = 16;
   localparam int SKID_ENTRIES = 3;
   localparam int PTR_W        = 2;
   localparam int OCC_W        = 2;

   typedef enum logic [1:0] {
      QOP_IDLE = 2'b00,
      QOP_POP  = 2'b01,
      QOP_PUSH = 2'b10,
      QOP_BOTH = 2'b11
   } queueOp_e;

   function automatic logic [PTR_W-1:0] ptrInc(input logic [PTR_W-1:0] ptr);
      return (ptr == PTR_W'(SKID_ENTRIES - 1)) ? '0 : ptr + 1'b1;
   endfunction

endpackage

// File: rtl/fifo_stream_reader_skid_queue.sv
// Three-entry circular output queue: push at the tail, pop from the head.
// A same-cycle push and pop moves both pointers and leaves the occupancy unchanged.
module skid_queue
   import fifo_stream_reader_pkg::*;
#(
   parameter int DATA_W = 8
)
(
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              push_i,
   input  logic [DATA_W-1:0] pushData_i,
   input  logic              pop_i,
   output logic [OCC_W-1:0]  occ_o,
   output logic [DATA_W-1:0] headData_o
);

   logic [DATA_W-1:0] mem_q [SKID_ENTRIES];
   logic [PTR_W-1:0]  head_q, head_d;
   logic [PTR_W-1:0]  tail_q, tail_d;
   logic [OCC_W-1:0]  occ_q, occ_d;
   queueOp_e          op;

   always_comb begin
      op     = queueOp_e'({push_i, pop_i});
      head_d = head_q;
      tail_d = tail_q;
      occ_d  = occ_q;
      case (op)
         QOP_PUSH: begin
            tail_d = ptrInc(tail_q);
            occ_d  = occ_q + 1'b1;
         end
         QOP_POP: begin
            head_d = ptrInc(head_q);
            occ_d  = occ_q - 1'b1;
         end
         QOP_BOTH: begin
            head_d = ptrInc(head_q);
            tail_d = ptrInc(tail_q);
         end
         default: begin
         end
      endcase
   end

   // Storage is cleared on reset so a flushed word never reappears on the output.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         head_q <= '0;
         tail_q <= '0;
         occ_q  <= '0;
         for (int i = 0; i < SKID_ENTRIES; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         head_q <= head_d;
         tail_q <= tail_d;
         occ_q  <= occ_d;
         if (push_i) begin
            mem_q[tail_q] <= pushData_i;
         end
      end
   end

   assign occ_o      = occ_q;
   assign headData_o = mem_q[head_q];

endmodule

// File: rtl/fifo_stream_reader.sv
// Reads words from a FIFO and presents them as a valid/ready stream through a skid queue.
// Read credit counts buffered plus in-flight words, so fifo_rd never depends on m_ready.
module fifo_stream_reader
   import fifo_stream_reader_pkg::*;
#(
   parameter int DATA_W     = 8,
   parameter int SKID_DEPTH = 3
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              fifo_empty,
   input  logic              fifo_wr,
   input  logic [DATA_W-1:0] fifo_dout,
   output logic              fifo_rd,
   output logic              m_valid,
   output logic [DATA_W-1:0] m_data,
   input  logic              m_ready,
   output logic              busy,
   output logic [15:0]       xfer_cnt
);

   localparam logic [OCC_W:0] CREDITS = (OCC_W+1)'(SKID_DEPTH);

   if (SKID_DEPTH != SKID_ENTRIES) begin : gDepthCheck
      $error("fifo_stream_reader: SKID_DEPTH must be 3");
   end

   logic              inflight_q, inflight_d;
   logic [15:0]       xferCnt_q, xferCnt_d;
   logic [OCC_W-1:0]  occ;
   logic [OCC_W:0]    creditUsed;
   logic [DATA_W-1:0] headData;
   logic              readAccept;
   logic              pop;

   // A read issued alongside a FIFO write is dropped by the FIFO, so it earns no in-flight word.
   always_comb begin
      creditUsed = {1'b0, occ} + (OCC_W+1)'(inflight_q);
      fifo_rd    = en && !fifo_empty && !rst && (creditUsed < CREDITS);
      readAccept = fifo_rd && !fifo_wr;
      inflight_d = readAccept;
      m_valid    = !rst && (occ != '0);
      m_data     = rst ? '0 : headData;
      busy       = !rst && ((occ != '0) || inflight_q);
      pop        = m_valid && m_ready;
      xferCnt_d  = pop ? xferCnt_q + 16'd1 : xferCnt_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         inflight_q <= 1'b0;
         xferCnt_q  <= '0;
      end else begin
         inflight_q <= inflight_d;
         xferCnt_q  <= xferCnt_d;
      end
   end

   skid_queue #(
      .DATA_W(DATA_W)
   ) uSkidQueue (
      .clk_i     (clk),
      .rst_i     (rst),
      .push_i    (inflight_q),
      .pushData_i(fifo_dout),
      .pop_i     (pop),
      .occ_o     (occ),
      .headData_o(headData)
   );

   assign xfer_cnt = xferCnt_q;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader with a small behavioural FIFO as the read source.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_fifo_stream_reader;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en = 1'b0;
   logic        fifo_empty = 1'b1;
   logic        fifo_wr = 1'b0;
   logic [7:0]  fifo_dout = 8'h00;
   logic        fifo_rd;
   logic        m_valid;
   logic [7:0]  m_data;
   logic        m_ready = 1'b0;
   logic        busy;
   logic [15:0] xfer_cnt;

   logic [7:0]  wrWord = 8'h00;
   logic        streamMode = 1'b0;
   logic [7:0]  streamWord = 8'h00;
   logic [7:0]  fifoQ [$];

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   fifo_stream_reader #(
      .DATA_W(8),
      .SKID_DEPTH(3)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .fifo_empty(fifo_empty),
      .fifo_wr   (fifo_wr),
      .fifo_dout (fifo_dout),
      .fifo_rd   (fifo_rd),
      .m_valid   (m_valid),
      .m_data    (m_data),
      .m_ready   (m_ready),
      .busy      (busy),
      .xfer_cnt  (xfer_cnt)
   );

   // FIFO model: writes win over reads; stream mode is an endless source of incrementing words.
   always @(posedge clk) begin
      if (fifo_wr) begin
         fifoQ.push_back(wrWord);
      end else if (fifo_rd) begin
         if (streamMode) begin
            fifo_dout  <= streamWord;
            streamWord <= streamWord + 8'd1;
         end else if (fifoQ.size() != 0) begin
            fifo_dout <= fifoQ.pop_front();
         end
      end
      fifo_empty <= !streamMode && (fifoQ.size() == 0);
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         failures++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic enV, input logic readyV, input logic wrV);
      en      = enV;
      m_ready = readyV;
      fifo_wr = wrV;
      #1;
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic pushWord(input logic [7:0] w);
      wrWord  = w;
      fifo_wr = 1'b1;
      @(negedge clk);
      fifo_wr = 1'b0;
      #1;
   endtask

   logic [7:0] bpWords [5];
   int cycles;

   initial begin
      bpWords[0] = 8'hA1; bpWords[1] = 8'hA2; bpWords[2] = 8'hA3;
      bpWords[3] = 8'hA4; bpWords[4] = 8'hA5;

      // Reset state
      applyStimulus(1'b0, 1'b0, 1'b0);
      tick();
      tick();
      checkOutput("rst_fifo_rd", fifo_rd, 1'b0);
      checkOutput("rst_m_valid", m_valid, 1'b0);
      checkOutput("rst_busy", busy, 1'b0);
      checkOutput("rst_m_data", m_data, 8'h00);
      checkOutput("rst_xfer_cnt", xfer_cnt, 16'h0000);
      rst = 1'b0;
      #1;

      // Basic: three preloaded words stream out back to back
      pushWord(8'h11);
      pushWord(8'h22);
      pushWord(8'h33);
      applyStimulus(1'b1, 1'b1, 1'b0);
      checkOutput("basic_first_rd", fifo_rd, 1'b1);
      tick();
      checkOutput("basic_lat1_valid", m_valid, 1'b0);
      checkOutput("basic_lat1_busy", busy, 1'b1);
      tick();
      checkOutput("basic_w0_valid", m_valid, 1'b1);
      checkOutput("basic_w0_data", m_data, 8'h11);
      tick();
      checkOutput("basic_w1_data", m_data, 8'h22);
      tick();
      checkOutput("basic_w2_data", m_data, 8'h33);
      checkOutput("basic_w2_rd", fifo_rd, 1'b0);
      tick();
      checkOutput("basic_done_valid", m_valid, 1'b0);
      checkOutput("basic_done_busy", busy, 1'b0);
      checkOutput("basic_xfer_cnt", xfer_cnt, 16'd3);

      // Backpressure: reads stop once three words are owed, head word holds
      applyStimulus(1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) pushWord(bpWords[i]);
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("bp_rd_start", fifo_rd, 1'b1);
      tick();
      tick();
      checkOutput("bp_rd_credit2", fifo_rd, 1'b1);
      tick();
      checkOutput("bp_rd_stop_inflight", fifo_rd, 1'b0);
      checkOutput("bp_hold_data0", m_data, 8'hA1);
      tick();
      checkOutput("bp_rd_stop_full", fifo_rd, 1'b0);
      checkOutput("bp_full_busy", busy, 1'b1);
      tick();
      tick();
      tick();
      checkOutput("bp_hold_valid", m_valid, 1'b1);
      checkOutput("bp_hold_data1", m_data, 8'hA1);
      checkOutput("bp_rd_stays_low", fifo_rd, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) begin
         checkOutput("bp_drain_valid", m_valid, 1'b1);
         checkOutput("bp_drain_data", m_data, bpWords[i]);
         tick();
      end
      checkOutput("bp_drained_valid", m_valid, 1'b0);
      checkOutput("bp_xfer_cnt", xfer_cnt, 16'd8);

      // Write collision: the colliding read is dropped and the word re-requested
      applyStimulus(1'b0, 1'b1, 1'b0);
      pushWord(8'hC1);
      pushWord(8'hC2);
      wrWord = 8'hC3;
      applyStimulus(1'b1, 1'b1, 1'b1);
      checkOutput("col_rd_issued", fifo_rd, 1'b1);
      tick();
      applyStimulus(1'b1, 1'b1, 1'b0);
      checkOutput("col_no_inflight_busy", busy, 1'b0);
      checkOutput("col_no_valid", m_valid, 1'b0);
      checkOutput("col_rd_again", fifo_rd, 1'b1);
      tick();
      tick();
      checkOutput("col_w0_data", m_data, 8'hC1);
      tick();
      checkOutput("col_w1_data", m_data, 8'hC2);
      tick();
      checkOutput("col_w2_data", m_data, 8'hC3);
      tick();
      checkOutput("col_done_valid", m_valid, 1'b0);
      checkOutput("col_xfer_cnt", xfer_cnt, 16'd11);

      // Reset mid-stream with two buffered words and one in flight
      applyStimulus(1'b0, 1'b0, 1'b0);
      pushWord(8'hD1);
      pushWord(8'hD2);
      pushWord(8'hD3);
      pushWord(8'hD4);
      pushWord(8'hD5);
      applyStimulus(1'b1, 1'b0, 1'b0);
      tick();
      tick();
      tick();
      checkOutput("mid_pre_busy", busy, 1'b1);
      checkOutput("mid_pre_data", m_data, 8'hD1);
      rst = 1'b1;
      #1;
      checkOutput("mid_rst_rd", fifo_rd, 1'b0);
      checkOutput("mid_rst_valid", m_valid, 1'b0);
      checkOutput("mid_rst_busy", busy, 1'b0);
      checkOutput("mid_rst_data", m_data, 8'h00);
      tick();
      checkOutput("mid_post_xfer", xfer_cnt, 16'd0);
      checkOutput("mid_post_valid", m_valid, 1'b0);
      checkOutput("mid_post_busy", busy, 1'b0);
      checkOutput("mid_post_rd", fifo_rd, 1'b0);
      rst = 1'b0;
      applyStimulus(1'b1, 1'b1, 1'b0);
      checkOutput("mid_resume_rd", fifo_rd, 1'b1);
      tick();
      tick();
      checkOutput("mid_resume_data0", m_data, 8'hD4);
      tick();
      checkOutput("mid_resume_data1", m_data, 8'hD5);
      tick();
      checkOutput("mid_resume_valid", m_valid, 1'b0);
      checkOutput("mid_resume_xfer", xfer_cnt, 16'd2);

      // Empty FIFO with en high, then a loaded FIFO with en low
      applyStimulus(1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 20; i++) begin
         checkOutput("empty_rd", fifo_rd, 1'b0);
         checkOutput("empty_valid", m_valid, 1'b0);
         tick();
      end
      applyStimulus(1'b0, 1'b1, 1'b0);
      pushWord(8'hE1);
      pushWord(8'hE2);
      for (int i = 0; i < 20; i++) begin
         checkOutput("disabled_rd", fifo_rd, 1'b0);
         checkOutput("disabled_valid", m_valid, 1'b0);
         tick();
      end
      applyStimulus(1'b1, 1'b1, 1'b0);
      tick();
      tick();
      checkOutput("enable_data0", m_data, 8'hE1);
      tick();
      checkOutput("enable_data1", m_data, 8'hE2);
      tick();
      checkOutput("enable_xfer", xfer_cnt, 16'd4);

      // Counter wrap under sustained one-per-cycle streaming
      rst = 1'b1;
      streamMode = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      applyStimulus(1'b1, 1'b1, 1'b0);
      cycles = 0;
      while (xfer_cnt !== 16'hFFFF && cycles < 70000) begin
         tick();
         cycles++;
      end
      checkOutput("wrap_cycles_to_ffff", cycles, 65537);
      checkOutput("wrap_data_ff", m_data, 8'hFF);
      checkOutput("wrap_valid_pre", m_valid, 1'b1);
      tick();
      checkOutput("wrap_xfer_zero", xfer_cnt, 16'h0000);
      checkOutput("wrap_data_00", m_data, 8'h00);
      checkOutput("wrap_valid_post", m_valid, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
